// File: rtl/proc_bus_mem_slave_pkg.sv
// Shared types and constants for the 16-bit ready/valid processor bus slave.
package proc_bus_pkg;

   localparam int PROC_DW = 16;
   localparam logic [PROC_DW-1:0] PROC_ERR_RDATA = 16'hDEAD;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} slv_state_e;

   typedef struct packed {
      logic [PROC_DW-1:0] addr;
      logic               we;
      logic [PROC_DW-1:0] wdata;
   } proc_req_t;

endpackage

// File: rtl/proc_bus_mem_slave_array.sv
// Single-port synchronous RAM, DEPTH x 16, with a registered read port.
module proc_mem_array
   import proc_bus_pkg::*;
#(
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [AW-1:0]      addr_i,
   input  logic [PROC_DW-1:0] wdata_i,
   output logic [PROC_DW-1:0] rdata_o
);

   logic [PROC_DW-1:0] mem [DEPTH];
   logic [PROC_DW-1:0] rdata_q;

   // Storage itself is never reset; only the read register has a known value.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/proc_bus_mem_slave.sv
// Word-addressed memory slave on the ready/valid bus with WAIT_STATES latency.
// Define PROC_MEM_ERR_EN to add the err port and out-of-range suppression.
module proc_bus_mem_slave
   import proc_bus_pkg::*;
#(
   parameter int               DEPTH       = 256,
   parameter int               WAIT_STATES = 1,
   parameter logic [PROC_DW-1:0] BASE_ADDR = 16'h0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PROC_DW-1:0] addr,
   input  logic [PROC_DW-1:0] wdata,
   input  logic               valid,
   input  logic               we,
   output logic [PROC_DW-1:0] rdata,
   output logic               ready
`ifdef PROC_MEM_ERR_EN
   ,
   output logic               err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   slv_state_e         state_q;
   proc_req_t          req_q;
   logic [3:0]         cnt_q;
   logic               ready_q;
   logic [PROC_DW-1:0] reqAddr;
   logic               reqWe;
   logic               reqOor;
   logic               goResp;
   logic [AW-1:0]      memIdx;
   logic               memWe;
   logic               memRe;
   logic [PROC_DW-1:0] memRdata;
`ifdef PROC_MEM_ERR_EN
   logic               err_q;
   logic               rdErr_q;
`endif

   // In IDLE the live request is used so a zero-wait read can launch the RAM
   // read on the capture edge; afterwards only the captured copy matters.
   always_comb begin
      reqAddr = (state_q == IDLE) ? addr : req_q.addr;
      reqWe   = (state_q == IDLE) ? we : req_q.we;
      memIdx  = AW'(reqAddr - BASE_ADDR);
      reqOor  = 1'b0;
`ifdef PROC_MEM_ERR_EN
      reqOor  = (reqAddr < BASE_ADDR) ||
                ((reqAddr - BASE_ADDR) >= PROC_DW'(DEPTH));
`endif
      goResp = 1'b0;
      case (state_q)
         IDLE:    goResp = valid && (WAIT_STATES == 0);
         WAIT:    goResp = valid && (cnt_q == 4'd1);
         default: goResp = 1'b0;
      endcase
      memRe = goResp && !reqWe && !reqOor;
      memWe = (state_q == RESP) && req_q.we && !reqOor;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
`ifdef PROC_MEM_ERR_EN
         err_q   <= 1'b0;
         rdErr_q <= 1'b0;
`endif
      end else begin
         ready_q <= goResp;
`ifdef PROC_MEM_ERR_EN
         err_q <= goResp && reqOor;
         if (goResp && !reqWe) begin
            rdErr_q <= reqOor;
         end
`endif
         case (state_q)
            IDLE: begin
               if (valid) begin
                  req_q.addr  <= addr;
                  req_q.we    <= we;
                  req_q.wdata <= wdata;
                  cnt_q       <= WS;
                  state_q     <= (WAIT_STATES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (!valid) begin
                  state_q <= IDLE;
               end else if (cnt_q == 4'd1) begin
                  state_q <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   proc_mem_array #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (memWe),
      .re_i    (memRe),
      .addr_i  (memIdx),
      .wdata_i (req_q.wdata),
      .rdata_o (memRdata)
   );

   assign ready = ready_q;
`ifdef PROC_MEM_ERR_EN
   assign rdata = rdErr_q ? PROC_ERR_RDATA : memRdata;
   assign err   = err_q;
`else
   assign rdata = memRdata;
`endif

endmodule

// File: tb/tb_proc_bus_mem_slave.sv
// Directed scoreboard bench for proc_bus_mem_slave: one instance with one wait
// state and one with zero wait states, sharing clock and reset.
module tb_proc_bus_mem_slave;

   logic        clk;
   logic        rst_n;
   logic [15:0] addrS   [2];
   logic [15:0] wdataS  [2];
   logic        validS  [2];
   logic        weS     [2];
   logic [15:0] rdataS  [2];
   logic        readyS  [2];
   logic [15:0] lastRd  [2];
   logic [15:0] rdQ     [$];
   int          total;
   int          bad;
`ifdef PROC_MEM_ERR_EN
   logic        errS    [2];
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   proc_bus_mem_slave #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(16'h0000)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addrS[0]),
      .wdata (wdataS[0]),
      .valid (validS[0]),
      .we    (weS[0]),
      .rdata (rdataS[0]),
      .ready (readyS[0])
`ifdef PROC_MEM_ERR_EN
      ,
      .err   (errS[0])
`endif
   );

   proc_bus_mem_slave #(.DEPTH(256), .WAIT_STATES(1), .BASE_ADDR(16'h0000)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addrS[1]),
      .wdata (wdataS[1]),
      .valid (validS[1]),
      .we    (weS[1]),
      .rdata (rdataS[1]),
      .ready (readyS[1])
`ifdef PROC_MEM_ERR_EN
      ,
      .err   (errS[1])
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete transfer on instance sel; optionally moves addr after capture.
   task automatic applyStimulus(input int sel, input logic [15:0] a, input logic w,
                                input logic [15:0] d, input logic [15:0] expRd,
                                input bit glitch, input logic [15:0] ga);
      int          cyc;
      logic [15:0] exp;
      @(negedge clk);
      addrS[sel]  = a;
      weS[sel]    = w;
      wdataS[sel] = d;
      validS[sel] = 1'b1;
      if (!w) rdQ.push_back(expRd);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (glitch && cyc == 1) addrS[sel] = ga;
      end while (!readyS[sel] && cyc < 20);
      checkOutput("latency", cyc, (sel == 1) ? 2 : 1);
      if (!w) begin
         exp = rdQ.pop_front();
         checkOutput("read data", rdataS[sel], exp);
         lastRd[sel] = exp;
      end else begin
         checkOutput("write keeps rdata", rdataS[sel], lastRd[sel]);
      end
`ifdef PROC_MEM_ERR_EN
      checkOutput("err", errS[sel], (a >= 16'd256) ? 1 : 0);
`endif
      @(posedge clk);
      #1;
      checkOutput("ready one cycle", readyS[sel], 0);
      checkOutput("rdata hold", rdataS[sel], lastRd[sel]);
      validS[sel] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         addrS[i] = '0; wdataS[i] = '0; validS[i] = 1'b0; weS[i] = 1'b0; lastRd[i] = '0;
      end
      #22;
      for (int i = 0; i < 2; i++) begin
         checkOutput("reset ready", readyS[i], 0);
         checkOutput("reset rdata", rdataS[i], 16'h0000);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write then read with one wait state
      applyStimulus(1, 16'h0010, 1'b1, 16'hA5A5, 16'h0, 1'b0, 16'h0);
      applyStimulus(1, 16'h0010, 1'b0, 16'h0000, 16'hA5A5, 1'b0, 16'h0);

      // Aborted write leaves old contents
      applyStimulus(1, 16'h0003, 1'b1, 16'h5555, 16'h0, 1'b0, 16'h0);
      @(negedge clk);
      addrS[1] = 16'h0003; weS[1] = 1'b1; wdataS[1] = 16'h1234; validS[1] = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort wait ready", readyS[1], 0);
      @(negedge clk);
      validS[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("abort no ready", readyS[1], 0);
      end
      applyStimulus(1, 16'h0003, 1'b0, 16'h0000, 16'h5555, 1'b0, 16'h0);

      // Reset during the wait phase of a write
      @(negedge clk);
      addrS[1] = 16'h0010; weS[1] = 1'b1; wdataS[1] = 16'h7777; validS[1] = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset ready", readyS[1], 0);
      checkOutput("midreset rdata", rdataS[1], 16'h0000);
      @(negedge clk);
      validS[1] = 1'b0;
      rst_n = 1'b1;
      lastRd[0] = '0;
      lastRd[1] = '0;
      applyStimulus(1, 16'h0010, 1'b0, 16'h0000, 16'hA5A5, 1'b0, 16'h0);

      // Aliasing or out-of-range handling
      applyStimulus(1, 16'h0005, 1'b1, 16'h1111, 16'h0, 1'b0, 16'h0);
      applyStimulus(1, 16'h0105, 1'b1, 16'hBEEF, 16'h0, 1'b0, 16'h0);
`ifdef PROC_MEM_ERR_EN
      applyStimulus(1, 16'h0005, 1'b0, 16'h0000, 16'h1111, 1'b0, 16'h0);
      applyStimulus(1, 16'h0105, 1'b0, 16'h0000, 16'hDEAD, 1'b0, 16'h0);
`else
      applyStimulus(1, 16'h0005, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 16'h0);
`endif

      // Address change after capture is ignored
      applyStimulus(1, 16'h0020, 1'b1, 16'h2222, 16'h0, 1'b0, 16'h0);
      applyStimulus(1, 16'h0030, 1'b1, 16'h3333, 16'h0, 1'b0, 16'h0);
      applyStimulus(1, 16'h0020, 1'b0, 16'h0000, 16'h2222, 1'b1, 16'h0030);

      // Zero wait states: prefill, then four back-to-back reads with valid held
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 16'(16'h0001 + k), 1'b1, 16'(16'hC000 + k), 16'h0, 1'b0, 16'h0);
      end
      @(negedge clk);
      addrS[0] = 16'h0001; weS[0] = 1'b0; validS[0] = 1'b1;
      for (int k = 0; k < 4; k++) rdQ.push_back(16'(16'hC000 + k));
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         checkOutput("b2b ready", readyS[0], 1);
         checkOutput("b2b rdata", rdataS[0], rdQ.pop_front());
         @(posedge clk);
         #1;
         checkOutput("b2b gap", readyS[0], 0);
         addrS[0] = 16'(16'h0002 + k);
      end
      validS[0] = 1'b0;

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/proc_bus_mem_slave.md
Name: proc_bus_mem_slave

Overview:
- Slave/responder end of the 16-bit ready/valid processor bus: a word-addressed, single-port data memory.
- Inserts a configurable number of wait states before handshaking, so it models a memory with realistic access latency.
- Sits behind the core's data/instruction port as the RTL memory model and as the UVM slave-side DUT stand-in.

Parameters:
- DEPTH, 256: number of 16-bit words; power of 2, range 2..4096.
- WAIT_STATES, 1: idle cycles between request capture and the ready pulse; range 0..15.
- BASE_ADDR, 16'h0000: word address of entry 0; must be DEPTH-aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  16  word address from master.
- wdata  input  16  write data from master.
- valid  input  1  master request valid.
- we  input  1  1 = write, 0 = read.
- rdata  output  16  read data, valid only while ready=1 on a read.
- ready  output  1  slave handshake; a transfer completes on the clk edge where valid and ready are both 1.
- err  output  1  out-of-range flag; present only with PROC_MEM_ERR_EN.

Behaviour:
- Reset (async on rst_n low):
  - ready=0, rdata=16'h0000, err=0, state=IDLE, counter=0.
  - Memory contents are not reset.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Index is addr - BASE_ADDR truncated to AW = clog2(DEPTH) bits; without the optional feature, upper bits alias.
- FSM states:
  - IDLE: on an edge with valid=1, capture addr, we and wdata, load counter=WAIT_STATES, go to WAIT. If WAIT_STATES=0, go directly to RESP.
  - WAIT: decrement counter each cycle; when it reaches 1, go to RESP.
  - RESP: ready=1 for exactly one cycle. For a read, rdata = mem[captured index] in the same cycle. For a write, mem[index] is updated on the handshake edge. Return to IDLE unconditionally.
- Latency: ready asserts WAIT_STATES+1 cycles after the edge that sampled valid. Throughput is one transfer per WAIT_STATES+2 cycles.
- Back-to-back requests: a master that re-asserts valid (or keeps it high) in the cycle after RESP is sampled by IDLE on that edge. No request is dropped.
- Master must hold valid, addr, we and wdata stable until the handshake. The slave uses only the captured copies; input changes after capture are ignored.
- valid deasserted while in WAIT: the request is aborted. Return to IDLE on the next edge, no write, ready stays 0.
- rdata holds its last value outside RESP. Write responses leave rdata unchanged.
- Read-after-write to the same address, back-to-back: the read returns the newly written value, because the write commits before the read's RESP.
- Reset asserted mid-transfer: return immediately to IDLE with ready=0. A write not yet handshaked is not committed.

Optional Feature:
- Macro: PROC_MEM_ERR_EN.
- With the macro defined:
  - Port err exists. A request is out of range when addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH.
  - An out-of-range request still handshakes with the same latency.
  - err=1 in the RESP cycle only. Writes are suppressed; reads return 16'hDEAD.
- Without the macro: no err port; addresses alias modulo DEPTH and no accesses are suppressed.

Decomposition:
- Package proc_bus_pkg holds:
  - PROC_DW=16.
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} slv_state_e.
  - PROC_ERR_RDATA=16'hDEAD.
  - typedef struct for the captured request (addr, we, wdata).
- Sub-module proc_mem_array: single-port synchronous RAM, DEPTH x 16, with a write enable and a registered read. The slave FSM drives it.

Test Plan:
- Reset, then WAIT_STATES=1: write 16'hA5A5 to addr 16'h0010 -> ready=1 exactly 2 cycles after valid is sampled, for one cycle. A following read of 16'h0010 -> rdata=16'hA5A5 with ready.
- WAIT_STATES=0: 4 back-to-back reads with valid held high -> 4 ready pulses, one every 2 cycles, no request lost.
- valid dropped during WAIT on a write of 16'h1234 to 16'h0003 -> no ready pulse; a later read of 16'h0003 returns the old value.
- Reset pulsed low during WAIT of a write -> ready=0, rdata=16'h0000 immediately; the memory location is unchanged after reset.
- DEPTH=256, BASE_ADDR=0: write 16'hBEEF to 16'h0105, read 16'h0005:
  - Without PROC_MEM_ERR_EN -> rdata=16'hBEEF (aliasing).
  - With PROC_MEM_ERR_EN -> the write sets err=1 and is suppressed; the read of 16'h0105 returns 16'hDEAD with err=1.
- Master changes addr while in WAIT (protocol violation) -> the response uses the originally captured address.
